// File: rtl/game_pkg.sv
// Shared types and constants for the whack-a-mole game controller.
package game_pkg;

  localparam int unsigned HOLE_W = 4;
  localparam int unsigned LIFE_W = 28;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_UP   = 2'd2,
    ST_OVER = 2'd3
  } game_state_e;

  localparam logic [1:0] DIFF_EASY = 2'b00;
  localparam logic [1:0] DIFF_MED  = 2'b01;
  localparam logic [1:0] DIFF_HARD = 2'b10;

  // Right-shift Galois form of x^8+x^6+x^5+x^4+1
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Map a random byte to a hole, stepping past the previous hole to avoid repeats
  function automatic logic [HOLE_W-1:0] pick_hole(input logic [7:0] rnd,
                                                  input logic [HOLE_W-1:0] prev,
                                                  input int unsigned n);
    int unsigned cand;
    cand = 32'(rnd) % n;
    if (cand == 32'(prev)) cand = (cand + 1) % n;
    return HOLE_W'(cand);
  endfunction

endpackage

// File: rtl/mole_scheduler_if.sv
// Control inputs and game outputs between the play layer and the mole scheduler.
interface mole_scheduler_if #(
  parameter int unsigned NUM_HOLES = 9
);
  logic                 start;
  logic                 spawn;
  logic [1:0]           difficulty;
  logic [NUM_HOLES-1:0] btn;
  logic [NUM_HOLES-1:0] mole_mask;
  logic                 hit;
  logic                 miss;
  logic [7:0]           score;
  logic [7:0]           moles_left;
  logic                 playing;
  logic                 game_over;

  modport master (
    output start, spawn, difficulty, btn,
    input  mole_mask, hit, miss, score, moles_left, playing, game_over
  );

  modport slave (
    input  start, spawn, difficulty, btn,
    output mole_mask, hit, miss, score, moles_left, playing, game_over
  );
endinterface

// File: rtl/lfsr8.sv
// Free-running 8-bit Galois LFSR used as the hole-selection entropy source.
module lfsr8
  import game_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] value
);

  always_ff @(posedge clk) begin
    if (reset) value <= SEED;
    else       value <= {1'b0, value[7:1]} ^ (value[0] ? LFSR_TAPS : 8'h00);
  end

endmodule

// File: rtl/mole_scheduler.sv
// Whack-a-mole round controller: spawns moles, times their life, scores presses.
module mole_scheduler
  import game_pkg::*;
#(
  parameter int unsigned NUM_HOLES  = 9,
  parameter int unsigned GAME_MOLES = 30,
  parameter int unsigned LIFE_EASY  = 150000000,
  parameter int unsigned LIFE_MED   = 90000000,
  parameter int unsigned LIFE_HARD  = 60000000,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic            CLK100MHZ,
  input  logic            reset,
  mole_scheduler_if.slave bus
);

  game_state_e       state;
  logic [7:0]        lfsr;
  logic [HOLE_W-1:0] prev_hole;
  logic [LIFE_W-1:0] life_cnt;

  logic [HOLE_W-1:0] hole_c;
  logic [LIFE_W-1:0] life_load_c;
  logic              press_c;
  logic              correct_c;
  logic              expire_c;

  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (CLK100MHZ),
    .reset (reset),
    .value (lfsr)
  );

  assign hole_c    = pick_hole(lfsr, prev_hole, NUM_HOLES);
  assign press_c   = |bus.btn;
  assign correct_c = (bus.btn == bus.mole_mask);
  // Expire on the cycle the counter would reach zero, so the mole is up LIFE cycles
  assign expire_c  = (life_cnt <= LIFE_W'(1));

  always_comb begin
    life_load_c = LIFE_W'(LIFE_EASY);
    case (bus.difficulty)
      DIFF_MED:  life_load_c = LIFE_W'(LIFE_MED);
      DIFF_HARD: life_load_c = LIFE_W'(LIFE_HARD);
      default:   life_load_c = LIFE_W'(LIFE_EASY);
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state          <= ST_IDLE;
      prev_hole      <= '0;
      life_cnt       <= '0;
      bus.mole_mask  <= '0;
      bus.hit        <= 1'b0;
      bus.miss       <= 1'b0;
      bus.score      <= 8'd0;
      bus.moles_left <= 8'(GAME_MOLES);
      bus.playing    <= 1'b0;
      bus.game_over  <= 1'b0;
    end else begin
      bus.hit  <= 1'b0;
      bus.miss <= 1'b0;
      case (state)
        ST_IDLE, ST_OVER: begin
          if (bus.start) begin
            state          <= ST_PLAY;
            bus.score      <= 8'd0;
            bus.moles_left <= 8'(GAME_MOLES);
            bus.playing    <= 1'b1;
            bus.game_over  <= 1'b0;
          end
        end
        ST_PLAY: begin
          if (bus.spawn) begin
            state         <= ST_UP;
            bus.mole_mask <= NUM_HOLES'(1) << hole_c;
            prev_hole     <= hole_c;
            life_cnt      <= life_load_c;
          end
        end
        ST_UP: begin
          life_cnt <= life_cnt - LIFE_W'(1);
          // A press outranks a simultaneous timeout
          if (press_c || expire_c) begin
            bus.mole_mask <= '0;
            life_cnt      <= '0;
            if (press_c && correct_c) begin
              bus.hit <= 1'b1;
              if (bus.score != 8'hFF) bus.score <= bus.score + 8'd1;
            end else begin
              bus.miss <= 1'b1;
            end
            bus.moles_left <= bus.moles_left - 8'd1;
            if (bus.moles_left == 8'd1) begin
              state         <= ST_OVER;
              bus.playing   <= 1'b0;
              bus.game_over <= 1'b1;
            end else begin
              state <= ST_PLAY;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mole_scheduler.sv
// Randomized scoreboard bench for mole_scheduler with a round-level reference model.
module tb_mole_scheduler;

  localparam int unsigned NH = 9;
  localparam int unsigned GM = 3;

  logic CLK100MHZ;
  logic reset;

  mole_scheduler_if #(.NUM_HOLES(NH)) bus ();

  mole_scheduler #(
    .NUM_HOLES  (NH),
    .GAME_MOLES (GM),
    .LIFE_EASY  (20),
    .LIFE_MED   (12),
    .LIFE_HARD  (8),
    .LFSR_SEED  (8'hA5)
  ) dut (
    .CLK100MHZ (CLK100MHZ),
    .reset     (reset),
    .bus       (bus)
  );

  typedef struct packed {
    logic       hit;
    logic       miss;
    logic [7:0] score;
    logic [7:0] ml;
    logic       go;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   score_m;
  int   ml_m;
  int   prev_hole_m;

  initial CLK100MHZ = 1'b0;
  always #5 CLK100MHZ = ~CLK100MHZ;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge CLK100MHZ);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int life_of(input logic [1:0] d);
    case (d)
      2'b01:   return 12;
      2'b10:   return 8;
      default: return 20;
    endcase
  endfunction

  // Monitor: every hit/miss pulse must match the next expected resolution
  always @(negedge CLK100MHZ) begin
    exp_t e;
    if (!reset && (bus.hit || bus.miss)) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: hit=%0b miss=%0b with nothing expected", bus.hit, bus.miss);
      end else begin
        e = expq.pop_front();
        if ({bus.hit, bus.miss, bus.score, bus.moles_left, bus.game_over} !== e) begin
          errors++;
          $display("FAIL resolution: got hit=%0b miss=%0b score=%0d left=%0d over=%0b expected hit=%0b miss=%0b score=%0d left=%0d over=%0b",
                   bus.hit, bus.miss, bus.score, bus.moles_left, bus.game_over,
                   e.hit, e.miss, e.score, e.ml, e.go);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mask"},  32'(bus.mole_mask), 32'd0);
    chk({tag, "_hit"},   32'(bus.hit), 32'd0);
    chk({tag, "_miss"},  32'(bus.miss), 32'd0);
    chk({tag, "_score"}, 32'(bus.score), 32'd0);
    chk({tag, "_left"},  32'(bus.moles_left), 32'(GM));
    chk({tag, "_play"},  32'(bus.playing), 32'd0);
    chk({tag, "_over"},  32'(bus.game_over), 32'd0);
  endtask

  task automatic start_round();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    score_m = 0;
    ml_m    = GM;
    chk("start_playing", 32'(bus.playing), 32'd1);
    chk("start_over",    32'(bus.game_over), 32'd0);
    chk("start_score",   32'(bus.score), 32'd0);
    chk("start_left",    32'(bus.moles_left), 32'(GM));
  endtask

  // kind: 0 no press, 1 correct, 2 wrong hole, 3 correct plus an extra bit
  task automatic do_mole(input logic [1:0] diff, input int kind, input int delay, input bit extra);
    int         life;
    int         res_cyc;
    int         hole;
    int         w;
    int         cleared;
    bit         pressed;
    logic [8:0] orig;
    logic [8:0] press;
    exp_t       e;
    life = life_of(diff);
    bus.spawn      = 1'b1;
    bus.difficulty = diff;
    step();
    bus.spawn = 1'b0;
    orig = bus.mole_mask;
    chk("mask_onehot", 32'($onehot(orig)), 32'd1);
    hole = 0;
    for (int i = 0; i < int'(NH); i++) if (orig[i]) hole = i;
    chk("hole_repeat", 32'(hole == prev_hole_m), 32'd0);
    prev_hole_m = hole;
    w = $urandom_range(0, NH - 2);
    if (w >= hole) w++;
    press = (kind == 1) ? orig : (kind == 2) ? (9'(1) << w) : (orig | (9'(1) << w));
    pressed = (kind != 0) && (delay >= 1) && (delay <= life);
    res_cyc = pressed ? delay : life;
    e.hit  = pressed && (kind == 1);
    e.miss = !e.hit;
    if (e.hit && score_m != 255) score_m++;
    ml_m--;
    e.score = 8'(score_m);
    e.ml    = 8'(ml_m);
    e.go    = (ml_m == 0);
    expq.push_back(e);
    cleared = 0;
    for (int k = 1; k <= life + 2 && cleared == 0; k++) begin
      if (pressed && k == delay) bus.btn = press;
      if (extra && k == 2 && res_cyc > 2) bus.spawn = 1'b1;
      step();
      bus.btn   = '0;
      bus.spawn = 1'b0;
      if (extra && k == 2 && res_cyc > 2) chk("spawn_in_up_mask", 32'(bus.mole_mask), 32'(orig));
      if (bus.mole_mask == '0) cleared = k;
    end
    chk("clear_cycle", 32'(cleared), 32'(res_cyc));
    chk("after_playing", 32'(bus.playing), 32'(ml_m != 0));
    chk("after_over",    32'(bus.game_over), 32'(ml_m == 0));
  endtask

  initial begin
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.spawn      = 1'b0;
    bus.difficulty = 2'b00;
    bus.btn        = '0;
    score_m        = 0;
    ml_m           = GM;
    prev_hole_m    = 0;
    repeat (3) step();
    check_reset_outputs("reset");
    reset = 1'b0;
    step();

    // Spawn and presses in IDLE are ignored
    bus.spawn = 1'b1;
    bus.btn   = '1;
    step();
    bus.spawn = 1'b0;
    bus.btn   = '0;
    step();
    chk("idle_spawn_mask", 32'(bus.mole_mask), 32'd0);
    chk("idle_playing",    32'(bus.playing), 32'd0);

    start_round();
    do_mole(2'b00, 1, 5, 1'b0);
    chk("t1_score", 32'(bus.score), 32'd1);
    chk("t1_left",  32'(bus.moles_left), 32'd2);
    do_mole(2'b10, 0, 0, 1'b0);
    do_mole(2'b00, 2, 3, 1'b0);

    // Round over: spawn and presses ignored, score held
    bus.spawn = 1'b1;
    bus.btn   = '1;
    step();
    bus.spawn = 1'b0;
    bus.btn   = '0;
    repeat (3) step();
    chk("over_mask",    32'(bus.mole_mask), 32'd0);
    chk("over_score",   32'(bus.score), 32'(score_m));
    chk("over_playing", 32'(bus.playing), 32'd0);
    chk("over_flag",    32'(bus.game_over), 32'd1);

    start_round();
    do_mole(2'b00, 3, 4, 1'b1);
    do_mole(2'b10, 1, 8, 1'b1);
    do_mole(2'b01, 1, 12, 1'b0);

    for (int n = 0; n < 200; n++) begin
      if (ml_m == 0) start_round();
      repeat ($urandom_range(0, 3)) begin
        bus.btn = 9'($urandom);
        step();
        bus.btn = '0;
      end
      do_mole(2'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(1, 24)), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a visible mole
    if (ml_m == 0) start_round();
    bus.spawn      = 1'b1;
    bus.difficulty = 2'b00;
    step();
    bus.spawn = 1'b0;
    chk("pre_reset_onehot", 32'($onehot(bus.mole_mask)), 32'd1);
    repeat (3) step();
    reset = 1'b1;
    step();
    check_reset_outputs("midup_reset");
    reset       = 1'b0;
    score_m     = 0;
    ml_m        = GM;
    prev_hole_m = 0;
    step();
    start_round();
    do_mole(2'b01, 0, 0, 1'b0);

    repeat (4) step();
    chk("queue_empty", 32'(expq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
